// File: rtl/hazard_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_scheduler
//  Description : Pipeline sequencing controller for the five-stage ARM core.
//                Tracks the destinations of the instructions in EXE and MEM
//                in a two-slot scoreboard. From it the block raises the ID
//                bubble request (hazard), the global SRAM wait-state hold
//                (freeze) and the branch clear (flush). It also counts stall
//                cycles and flags SRAM accesses that never complete.
//
//  Parameters  : MEM_TIMEOUT  wait cycles allowed in MEM_WAIT (1..255)
//                CNT_W        width of the saturating stall counter
//
//  Ports       : clk               clock, rising edge
//                rst               synchronous reset, active low
//                id_src1/_valid    Rn address of the ID instruction + read enable
//                id_src2/id_two_src Rm (Rd for STR) address + read enable
//                id_dest           destination of the ID instruction
//                id_wb_en          ID instruction writes back (condition-gated)
//                id_mem_r_en       ID instruction is a load
//                exe_branch_taken  EXE holds a taken branch
//                mem_access        MEM stage issues an SRAM read or write
//                mem_ready         SRAM completes the access this cycle
//                hazard            bubble into ID/EXE, hold PC and IF/ID
//                freeze            hold every pipeline register
//                flush             clear IF/ID and ID/EXE
//                mem_error         sticky SRAM timeout flag
//                stall_count       saturating count of hazard-or-freeze cycles
//
//  Build option: define HAZARD_FORWARDING_EN when the EX stage has operand
//                forwarding; only load-use in EXE then stalls. The port list
//                is the same in both builds.
//
//  Revision    : 1.0  initial release
// ============================================================================
module hazard_scheduler #(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       id_src1,
  input  logic             id_src1_valid,
  input  logic [3:0]       id_src2,
  input  logic             id_two_src,
  input  logic [3:0]       id_dest,
  input  logic             id_wb_en,
  input  logic             id_mem_r_en,
  input  logic             exe_branch_taken,
  input  logic             mem_access,
  input  logic             mem_ready,
  output logic             hazard,
  output logic             freeze,
  output logic             flush,
  output logic             mem_error,
  output logic [CNT_W-1:0] stall_count
);

  localparam logic [7:0]       c_TIMEOUT  = 8'(MEM_TIMEOUT);
  localparam logic [CNT_W-1:0] c_CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] c_CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  // --------------------------------------------------------------------------
  // Scoreboard slot: one in-flight instruction's write-back footprint
  // --------------------------------------------------------------------------
  typedef struct packed {
    logic       v;
    logic [3:0] dest;
    logic       wb;
    logic       mr;
  } slot_t;

  localparam slot_t c_SLOT_EMPTY = '0;

  typedef enum logic [0:0] {
    ST_RUN      = 1'b0,
    ST_MEM_WAIT = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [7:0]       r_wait_cnt;
  logic [7:0]       w_wait_nxt;
  logic             w_timeout;
  logic             w_freeze;

  slot_t            r_exe_slot;
  slot_t            r_mem_slot;
  slot_t            w_id_slot;

  logic             w_src1_hit;
  logic             w_src2_hit;
  logic             w_h_raw;
  logic             w_flush;
  logic             w_hazard;

  logic             r_mem_error;
  logic [CNT_W-1:0] r_stall_cnt;

  // A slot claims register x only if it is live and actually writes back.
  function automatic logic f_match(input slot_t s, input logic [3:0] x);
    return s.v & s.wb & (s.dest == x);
  endfunction

  // --------------------------------------------------------------------------
  // RAW detection
  // --------------------------------------------------------------------------
`ifdef HAZARD_FORWARDING_EN
  // ALU results in EXE and anything in MEM are bypassed into EX, so only a
  // load still in EXE (data not yet back from SRAM) forces a bubble.
  always_comb begin
    w_src1_hit = id_src1_valid & r_exe_slot.mr & f_match(r_exe_slot, id_src1);
    w_src2_hit = id_two_src    & r_exe_slot.mr & f_match(r_exe_slot, id_src2);
  end

  // The MEM slot is still shifted so the scoreboard holds the same contents
  // in both builds; this rule simply never consults it.
  logic w_unused_slot_bits;
  assign w_unused_slot_bits = ^r_mem_slot;
`else
  // No bypass network: any pending writer in EXE or MEM blocks the read.
  // WB is not tracked because the register file writes in the first half of
  // the cycle and ID reads the new value in the second half.
  always_comb begin
    w_src1_hit = id_src1_valid &
                 (f_match(r_exe_slot, id_src1) | f_match(r_mem_slot, id_src1));
    w_src2_hit = id_two_src &
                 (f_match(r_exe_slot, id_src2) | f_match(r_mem_slot, id_src2));
  end

  // Load flags only matter to the forwarding rule.
  logic w_unused_slot_bits;
  assign w_unused_slot_bits = r_exe_slot.mr ^ r_mem_slot.mr;
`endif

  assign w_h_raw = w_src1_hit | w_src2_hit;

  // --------------------------------------------------------------------------
  // SRAM wait-state FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= ST_RUN;
      r_wait_cnt <= 8'd0;
    end else begin
      r_state    <= w_state_nxt;
      r_wait_cnt <= w_wait_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_wait_nxt  = r_wait_cnt;
    w_freeze    = 1'b0;
    w_timeout   = 1'b0;
    case (r_state)
      ST_RUN: begin
        // The first cycle of a slow access already freezes; it counts as
        // wait cycle 1, so the timeout covers MEM_TIMEOUT+1 frozen cycles.
        if (mem_access && !mem_ready) begin
          w_freeze    = 1'b1;
          w_state_nxt = ST_MEM_WAIT;
          w_wait_nxt  = 8'd1;
        end
      end
      ST_MEM_WAIT: begin
        // Freeze covers the completion cycle too so MEM can capture the
        // SRAM data before the pipeline advances.
        w_freeze = 1'b1;
        if (mem_ready) begin
          w_state_nxt = ST_RUN;
          w_wait_nxt  = 8'd0;
        end else if (r_wait_cnt == c_TIMEOUT) begin
          w_timeout   = 1'b1;
          w_state_nxt = ST_RUN;
          w_wait_nxt  = 8'd0;
        end else begin
          w_wait_nxt = r_wait_cnt + 8'd1;
        end
      end
      default: begin
        w_state_nxt = ST_RUN;
        w_wait_nxt  = 8'd0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Output priority: freeze > flush > hazard
  // --------------------------------------------------------------------------
  assign w_flush  = exe_branch_taken & ~w_freeze;
  assign w_hazard = w_h_raw & ~w_freeze & ~w_flush;

  // --------------------------------------------------------------------------
  // Scoreboard shift
  // --------------------------------------------------------------------------
  always_comb begin
    w_id_slot      = c_SLOT_EMPTY;
    w_id_slot.v    = 1'b1;
    w_id_slot.dest = id_dest;
    w_id_slot.wb   = id_wb_en;
    w_id_slot.mr   = id_mem_r_en;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_exe_slot <= c_SLOT_EMPTY;
      r_mem_slot <= c_SLOT_EMPTY;
    end else if (!w_freeze) begin
      r_mem_slot <= r_exe_slot;
      // A flushed or stalled ID instruction does not enter EXE.
      if (w_flush || w_hazard) begin
        r_exe_slot <= c_SLOT_EMPTY;
      end else begin
        r_exe_slot <= w_id_slot;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Status: sticky timeout flag and saturating stall counter
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_mem_error <= 1'b0;
      r_stall_cnt <= '0;
    end else begin
      if (w_timeout) begin
        r_mem_error <= 1'b1;
      end
      if ((w_hazard || w_freeze) && (r_stall_cnt != c_CNT_MAX)) begin
        r_stall_cnt <= r_stall_cnt + c_CNT_ONE;
      end
    end
  end

  assign hazard      = w_hazard;
  assign freeze      = w_freeze;
  assign flush       = w_flush;
  assign mem_error   = r_mem_error;
  assign stall_count = r_stall_cnt;

endmodule
`default_nettype wire

// File: tb/tb_hazard_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hazard_scheduler
//  Description : Self-checking bench for hazard_scheduler. Directed scenarios
//                plus a randomized run compared against a pipeline-history
//                reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_hazard_scheduler;

  localparam int TB_TIMEOUT = 15;
  localparam int TB_CNT_W   = 6;
  localparam int CNT_MAX    = (1 << TB_CNT_W) - 1;

  logic                clk = 1'b0;
  logic                rst;
  logic [3:0]          id_src1;
  logic                id_src1_valid;
  logic [3:0]          id_src2;
  logic                id_two_src;
  logic [3:0]          id_dest;
  logic                id_wb_en;
  logic                id_mem_r_en;
  logic                exe_branch_taken;
  logic                mem_access;
  logic                mem_ready;
  logic                hazard;
  logic                freeze;
  logic                flush;
  logic                mem_error;
  logic [TB_CNT_W-1:0] stall_count;

  hazard_scheduler #(
    .MEM_TIMEOUT (TB_TIMEOUT),
    .CNT_W       (TB_CNT_W)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .id_src1          (id_src1),
    .id_src1_valid    (id_src1_valid),
    .id_src2          (id_src2),
    .id_two_src       (id_two_src),
    .id_dest          (id_dest),
    .id_wb_en         (id_wb_en),
    .id_mem_r_en      (id_mem_r_en),
    .exe_branch_taken (exe_branch_taken),
    .mem_access       (mem_access),
    .mem_ready        (mem_ready),
    .hazard           (hazard),
    .freeze           (freeze),
    .flush            (flush),
    .mem_error        (mem_error),
    .stall_count      (stall_count)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  // --------------------------------------------------------------------------
  // Reference model: history of the last two instructions that left ID
  // (index 0 = now in EXE, index 1 = now in MEM), plus the length of the
  // current SRAM wait measured in frozen cycles.
  // --------------------------------------------------------------------------
  typedef struct {
    bit       v;
    bit [3:0] dest;
    bit       wb;
    bit       mr;
  } instr_t;

  instr_t hist[$];
  int     waited;
  bit     m_err;
  int     m_cnt;
  bit     exp_hazard, exp_freeze, exp_flush;

  function automatic bit id_reads(instr_t e);
    return e.v && e.wb &&
           ((id_src1_valid && e.dest == id_src1) || (id_two_src && e.dest == id_src2));
  endfunction

  task automatic eval_model();
    bit raw;
    raw = 1'b0;
`ifdef HAZARD_FORWARDING_EN
    if (hist.size() > 0 && hist[0].mr && id_reads(hist[0])) raw = 1'b1;
`else
    foreach (hist[i]) if (id_reads(hist[i])) raw = 1'b1;
`endif
    exp_freeze = (waited > 0) || (mem_access && !mem_ready);
    exp_flush  = exe_branch_taken && !exp_freeze;
    exp_hazard = raw && !exp_freeze && !exp_flush;
  endtask

  task automatic update_model();
    instr_t e;
    if (!rst) begin
      hist.delete();
      waited = 0;
      m_err  = 1'b0;
      m_cnt  = 0;
      return;
    end
    if ((exp_hazard || exp_freeze) && m_cnt < CNT_MAX) m_cnt++;
    if (!exp_freeze) begin
      e.v = 1'b0; e.dest = 4'd0; e.wb = 1'b0; e.mr = 1'b0;
      if (!(exp_flush || exp_hazard)) begin
        e.v = 1'b1; e.dest = id_dest; e.wb = id_wb_en; e.mr = id_mem_r_en;
      end
      hist.push_front(e);
      if (hist.size() > 2) void'(hist.pop_back());
    end
    if (waited == 0) begin
      if (mem_access && !mem_ready) waited = 1;
    end else if (mem_ready) begin
      waited = 0;
    end else if (waited == TB_TIMEOUT) begin
      m_err  = 1'b1;
      waited = 0;
    end else begin
      waited++;
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled on
  // the falling edge; the model advances on the rising edge.
  task automatic settle();
    @(negedge clk);
    eval_model();
  endtask

  task automatic step();
    @(posedge clk);
    update_model();
    #1;
  endtask

  task automatic set_id(input logic [3:0] s1, input logic v1, input logic [3:0] s2,
                        input logic two, input logic [3:0] d, input logic wb,
                        input logic mr);
    id_src1 = s1; id_src1_valid = v1; id_src2 = s2; id_two_src = two;
    id_dest = d;  id_wb_en = wb;      id_mem_r_en = mr;
  endtask

  task automatic idle();
    rst = 1'b1;
    set_id(4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0);
    exe_branch_taken = 1'b0;
    mem_access       = 1'b0;
    mem_ready        = 1'b0;
  endtask

  // Two harmless instructions push any earlier writers out of the scoreboard.
  task automatic drain();
    idle();
    for (int i = 0; i < 2; i++) begin settle(); step(); end
  endtask

  // --------------------------------------------------------------------------
  // Scenarios
  // --------------------------------------------------------------------------
  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      rst = 1'b0;
      set_id(4'($urandom), 1'($urandom), 4'($urandom), 1'($urandom),
             4'($urandom), 1'($urandom), 1'($urandom));
      exe_branch_taken = 1'($urandom);
      mem_access       = 1'($urandom);
      mem_ready        = 1'($urandom);
      settle(); step();
    end
    idle();
    settle();
    vectors++; if (hazard !== 1'b0) begin miscompares++; $display("FAIL reset_hazard: got %b want 0", hazard); end
    vectors++; if (freeze !== 1'b0) begin miscompares++; $display("FAIL reset_freeze: got %b want 0", freeze); end
    vectors++; if (flush !== 1'b0) begin miscompares++; $display("FAIL reset_flush: got %b want 0", flush); end
    vectors++; if (mem_error !== 1'b0) begin miscompares++; $display("FAIL reset_mem_error: got %b want 0", mem_error); end
    vectors++; if (stall_count !== '0) begin miscompares++; $display("FAIL reset_stall_count: got %0d want 0", stall_count); end
    step();
  endtask

  task automatic test_raw_stall();
    bit want;
    drain();
    set_id(4'd0, 1'b0, 4'd0, 1'b0, 4'd3, 1'b1, 1'b0);   // ADD r3
    settle(); step();
    set_id(4'd3, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0);   // reads r3
    for (int c = 0; c < 3; c++) begin
      settle();
`ifdef HAZARD_FORWARDING_EN
      want = 1'b0;
`else
      want = (c < 2);
`endif
      vectors++; if (hazard !== want) begin miscompares++; $display("FAIL raw_hazard[%0d]: got %b want %b", c, hazard, want); end
      if (c == 2) begin
`ifdef HAZARD_FORWARDING_EN
        vectors++; if (stall_count !== TB_CNT_W'(0)) begin miscompares++; $display("FAIL raw_stall_count: got %0d want 0", stall_count); end
`else
        vectors++; if (stall_count !== TB_CNT_W'(2)) begin miscompares++; $display("FAIL raw_stall_count: got %0d want 2", stall_count); end
`endif
      end
      step();
    end
  endtask

  task automatic test_load_use();
    bit want;
    drain();
    set_id(4'd0, 1'b0, 4'd0, 1'b0, 4'd5, 1'b1, 1'b1);   // LDR r5
    settle(); step();
    set_id(4'd0, 1'b0, 4'd5, 1'b1, 4'd0, 1'b0, 1'b0);   // reads r5 as src2
    for (int c = 0; c < 3; c++) begin
      settle();
`ifdef HAZARD_FORWARDING_EN
      want = (c < 1);
`else
      want = (c < 2);
`endif
      vectors++; if (hazard !== want) begin miscompares++; $display("FAIL load_use_hazard[%0d]: got %b want %b", c, hazard, want); end
      step();
    end
  endtask

  task automatic test_sram_wait();
    bit want;
    drain();
    set_id(4'd0, 1'b0, 4'd0, 1'b0, 4'd7, 1'b1, 1'b0);   // writer of r7 into EXE
    settle(); step();
    set_id(4'd7, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0);   // reader of r7 held in ID
    mem_access = 1'b1;
    for (int c = 0; c < 5; c++) begin
      mem_ready = (c == 4);
      settle();
      vectors++; if (freeze !== 1'b1) begin miscompares++; $display("FAIL sram_freeze[%0d]: got %b want 1", c, freeze); end
      vectors++; if (hazard !== 1'b0) begin miscompares++; $display("FAIL sram_hazard_masked[%0d]: got %b want 0", c, hazard); end
      step();
    end
    mem_access = 1'b0; mem_ready = 1'b0;
    // Slots must still hold the r7 writer in EXE after the wait.
    for (int c = 0; c < 3; c++) begin
      settle();
`ifdef HAZARD_FORWARDING_EN
      want = 1'b0;
`else
      want = (c < 2);
`endif
      vectors++; if (freeze !== 1'b0) begin miscompares++; $display("FAIL sram_release[%0d]: got %b want 0", c, freeze); end
      vectors++; if (hazard !== want) begin miscompares++; $display("FAIL sram_slots_held[%0d]: got %b want %b", c, hazard, want); end
      vectors++; if (mem_error !== 1'b0) begin miscompares++; $display("FAIL sram_mem_error[%0d]: got %b want 0", c, mem_error); end
      step();
    end
  endtask

  task automatic test_timeout();
    drain();
    mem_access = 1'b1; mem_ready = 1'b0;
    for (int c = 0; c < TB_TIMEOUT + 1; c++) begin
      settle();
      vectors++; if (freeze !== 1'b1) begin miscompares++; $display("FAIL timeout_freeze[%0d]: got %b want 1", c, freeze); end
      vectors++; if (mem_error !== 1'b0) begin miscompares++; $display("FAIL timeout_early_error[%0d]: got %b want 0", c, mem_error); end
      step();
    end
    mem_access = 1'b0;
    for (int c = 0; c < 4; c++) begin
      settle();
      vectors++; if (freeze !== 1'b0) begin miscompares++; $display("FAIL timeout_release[%0d]: got %b want 0", c, freeze); end
      vectors++; if (mem_error !== 1'b1) begin miscompares++; $display("FAIL timeout_mem_error[%0d]: got %b want 1", c, mem_error); end
      step();
    end
  endtask

  task automatic test_branch_vs_hazard();
    drain();
    set_id(4'd0, 1'b0, 4'd0, 1'b0, 4'd4, 1'b1, 1'b0);   // writer of r4
    settle(); step();
    set_id(4'd4, 1'b1, 4'd0, 1'b0, 4'd9, 1'b1, 1'b1);   // r4 reader, itself LDR r9
    exe_branch_taken = 1'b1;
    settle();
    vectors++; if (flush !== 1'b1) begin miscompares++; $display("FAIL branch_flush: got %b want 1", flush); end
    vectors++; if (hazard !== 1'b0) begin miscompares++; $display("FAIL branch_hazard: got %b want 0", hazard); end
    step();
    exe_branch_taken = 1'b0;
    set_id(4'd9, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0);   // would hit r9 if it entered EXE
    settle();
    vectors++; if (hazard !== 1'b0) begin miscompares++; $display("FAIL branch_exe_bubble: got %b want 0", hazard); end
    step();
    idle();
    exe_branch_taken = 1'b1; mem_access = 1'b1;
    for (int c = 0; c < 3; c++) begin
      mem_ready = (c == 2);
      settle();
      vectors++; if (flush !== 1'b0) begin miscompares++; $display("FAIL branch_frozen_flush[%0d]: got %b want 0", c, flush); end
      step();
    end
    mem_access = 1'b0; mem_ready = 1'b0;
    settle();
    vectors++; if (flush !== 1'b1) begin miscompares++; $display("FAIL branch_after_freeze: got %b want 1", flush); end
    step();
    idle();
  endtask

  task automatic test_saturation();
    drain();
    mem_access = 1'b1; mem_ready = 1'b0;
    for (int c = 0; c < CNT_MAX + 12; c++) begin settle(); step(); end
    settle();
    vectors++; if (stall_count !== TB_CNT_W'(CNT_MAX)) begin miscompares++; $display("FAIL stall_saturate: got %0d want %0d", stall_count, CNT_MAX); end
    step();
    mem_access = 1'b0;
    settle();
    vectors++; if (stall_count !== TB_CNT_W'(CNT_MAX)) begin miscompares++; $display("FAIL stall_no_wrap: got %0d want %0d", stall_count, CNT_MAX); end
    step();
  endtask

  task automatic test_random();
    for (int n = 0; n < 1500; n++) begin
      rst = ($urandom_range(0, 149) != 0);
      set_id(4'($urandom_range(0, 3)), 1'($urandom), 4'($urandom_range(0, 3)),
             1'($urandom), 4'($urandom_range(0, 3)), 1'($urandom), 1'($urandom));
      exe_branch_taken = ($urandom_range(0, 7) == 0);
      mem_access       = ($urandom_range(0, 3) == 0);
      mem_ready        = ($urandom_range(0, 2) == 0);
      settle();
      vectors++; if (hazard !== exp_hazard) begin miscompares++; $display("FAIL rand_hazard@%0d: got %b want %b", n, hazard, exp_hazard); end
      vectors++; if (freeze !== exp_freeze) begin miscompares++; $display("FAIL rand_freeze@%0d: got %b want %b", n, freeze, exp_freeze); end
      vectors++; if (flush !== exp_flush) begin miscompares++; $display("FAIL rand_flush@%0d: got %b want %b", n, flush, exp_flush); end
      vectors++; if (mem_error !== m_err) begin miscompares++; $display("FAIL rand_mem_error@%0d: got %b want %b", n, mem_error, m_err); end
      vectors++; if (stall_count !== TB_CNT_W'(m_cnt)) begin miscompares++; $display("FAIL rand_stall_count@%0d: got %0d want %0d", n, stall_count, m_cnt); end
      step();
    end
  endtask

  initial begin
    waited = 0; m_err = 1'b0; m_cnt = 0;
    idle();
    rst = 1'b0;
    #1;
    test_reset();
    test_raw_stall();
    test_load_use();
    test_sram_wait();
    test_timeout();
    test_branch_vs_hazard();
    test_saturation();
    test_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/hazard_scheduler.md
Name: hazard_scheduler

Overview:
- Pipeline sequencing controller for the five-stage ARM core.
- Keeps an internal scoreboard of the destinations held by the instructions in EXE and MEM.
- Generates the ID-stage `hazard` (bubble insert), the global `freeze` for SRAM wait states, and the branch `flush`.
- Also counts stall cycles and flags memory timeouts.

Parameters:
- MEM_TIMEOUT, 15, maximum wait cycles in MEM_WAIT before the access is abandoned (must be 1..255).
- CNT_W, 16, width of the stall counter.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  synchronous active-low reset.
- id_src1  in  4  Rn address of the instruction in ID.
- id_src1_valid  in  1  ID instruction reads Rn.
- id_src2  in  4  Rm (or Rd for STR) address of the instruction in ID.
- id_two_src  in  1  ID instruction reads the second source.
- id_dest  in  4  destination of the ID instruction.
- id_wb_en  in  1  ID instruction writes back (already condition-gated).
- id_mem_r_en  in  1  ID instruction is a load.
- exe_branch_taken  in  1  EXE holds a taken branch.
- mem_access  in  1  MEM stage is issuing an SRAM read or write.
- mem_ready  in  1  SRAM completes the access this cycle.
- hazard  out  1  insert a bubble into ID/EXE and hold PC and IF/ID.
- freeze  out  1  hold every pipeline register.
- flush  out  1  clear IF/ID and ID/EXE.
- mem_error  out  1  sticky flag: an SRAM access timed out.
- stall_count  out  CNT_W  saturating count of hazard-or-freeze cycles.

Behaviour:
- Scoreboard has two slots, EXE and MEM. Each slot holds {v, dest[3:0], wb, mr}.
- Reset (rst=0 at the edge):
  - Both slots cleared (v=0).
  - State RUN, wait counter 0, stall_count 0, mem_error 0.
  - The outputs therefore evaluate to hazard=0, freeze=0, flush=0.
- Match term: m(s,x) = s.v & s.wb & (s.dest==x).
- Raw hazard, h_raw:
  - src1 term: id_src1_valid & (m(EXE,id_src1) | m(MEM,id_src1)).
  - src2 term: id_two_src & (m(EXE,id_src2) | m(MEM,id_src2)).
  - h_raw is the OR of the two terms.
- FSM states: RUN and MEM_WAIT. The wait counter is an internal 8-bit register.
- In RUN:
  - If mem_access & ~mem_ready: freeze=1, go to MEM_WAIT, wait counter <= 1.
  - Otherwise freeze=0.
- In MEM_WAIT: freeze=1.
  - If mem_ready: go to RUN; freeze still 1 this cycle and deasserts next cycle.
  - Else if wait counter == MEM_TIMEOUT: mem_error <= 1 and go to RUN.
  - Else the wait counter increments.
- Output priority is freeze > flush > hazard:
  - flush = exe_branch_taken & ~freeze.
  - hazard = h_raw & ~freeze & ~flush.
- Slot update, when freeze=1: both slots hold.
- Slot update, when freeze=0:
  - MEM slot <= EXE slot.
  - EXE slot <= bubble (v=0) if flush or hazard.
  - Otherwise EXE slot <= {1, id_dest, id_wb_en, id_mem_r_en}.
- A write-back in the same cycle as a hazard is not treated as forwarded. The register file writes in the first half-cycle, so the WB stage is never scoreboarded.
- stall_count increments when (hazard | freeze) and it is below all-ones. It saturates and never wraps.
- Reset mid-MEM_WAIT: state returns to RUN and freeze drops the next cycle, even if mem_ready was never seen.
- Simultaneous flush and h_raw: flush wins; hazard=0 and the EXE slot becomes a bubble.
- Inputs are sampled only while freeze=0. The upstream stages hold them stable during freeze.

Optional Feature:
- Macro: HAZARD_FORWARDING_EN.
- When defined:
  - The EX stage has operand forwarding.
  - h_raw considers only load-use: the EXE slot with mr=1 matching an enabled source.
  - MEM-slot matches and non-load EXE matches cause no stall.
- When undefined: the full two-slot RAW check described above applies.
- The port list is identical in both builds.

Test Plan:
- Reset: hold rst=0 for 2 cycles with random inputs -> hazard=0, freeze=0, flush=0, mem_error=0, stall_count=0 after release.
- RAW stall (no macro):
  - Stimulus: ADD dest=3 (wb=1) enters; next cycle ID has src1=3, src1_valid=1.
  - Required: hazard=1 for 2 cycles (match in EXE, then in MEM), then 0; stall_count=2.
- With HAZARD_FORWARDING_EN:
  - Same ADD sequence -> hazard stays 0.
  - LDR dest=5 (mr=1) followed by src2=5 with two_src=1 -> hazard=1 for exactly 1 cycle.
- SRAM wait: mem_access=1 with mem_ready low for 4 cycles, then high -> freeze=1 for 5 cycles, slots unchanged throughout, mem_error=0.
- Timeout: mem_ready never asserted with MEM_TIMEOUT=15 -> freeze high for 16 cycles, mem_error=1 and stays 1 until reset.
- Branch vs hazard:
  - Stimulus: exe_branch_taken=1 while h_raw=1.
  - Required: flush=1, hazard=0, EXE slot empty next cycle.
  - Repeat during MEM_WAIT -> flush=0 until freeze drops.
